// File: rtl/switch_conditioner_pkg.sv
// switch_conditioner_pkg: hold FSM state encoding and 25 MHz board timing defaults
package switch_conditioner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } hold_state_e;

   localparam int BOARD_CLK_HZ       = 25_000_000;
   localparam int DEF_DEBOUNCE_LIMIT = BOARD_CLK_HZ / 100;
   localparam int DEF_REPEAT_DELAY   = BOARD_CLK_HZ / 2;
   localparam int DEF_REPEAT_RATE    = BOARD_CLK_HZ / 10;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: two-flop synchroniser and debounce counter; o_rise/o_fall are
// combinational strobes high in the cycle whose closing edge flips o_level.
module sync_debounce
   import switch_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_switch,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int DW = $clog2(DEBOUNCE_LIMIT);
   localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_LIMIT - 1);

   logic          s1_q, s2_q, level_q, level_d, change;
   logic [DW-1:0] cnt_q, cnt_d;

   always_comb begin
      change  = (s2_q != level_q) && (cnt_q == CNT_LAST);
      cnt_d   = (s2_q == level_q || change) ? '0 : cnt_q + 1'b1;
      level_d = change ? s2_q : level_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= i_switch;
         s2_q    <= s1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_level = level_q;
   assign o_rise  = change & s2_q;
   assign o_fall  = change & ~s2_q;

endmodule

// File: rtl/switch_conditioner.sv
// switch_conditioner: debounced level, press/release pulses and hold-to-repeat
// step strobe for a raw push-button input.
module switch_conditioner
   import switch_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
   parameter bit REPEAT_EN      = 1'b1,
   parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_switch,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_repeat,
   output logic o_step
);

   localparam int RW = $clog2(imax(REPEAT_DELAY, REPEAT_RATE));
   localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

   logic          rise, fall;
   logic          press_q, release_q, rep_q, rep_d;
   hold_state_e   state_q, state_d;
   logic [RW-1:0] rcnt_q, rcnt_d;

   sync_debounce #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
   ) u_sync_debounce (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_switch(i_switch),
      .o_level (o_level),
      .o_rise  (rise),
      .o_fall  (fall)
   );

   // Release is checked first so a repeat due on the release edge is dropped
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q + 1'b1;
      rep_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rcnt_d = '0;
            if (rise && REPEAT_EN) state_d = ST_HOLD;
         end
         ST_HOLD, ST_REPEAT: begin
            if (fall) begin
               state_d = ST_IDLE;
               rcnt_d  = '0;
            end else if (rcnt_q == ((state_q == ST_HOLD) ? DLY_LAST : RATE_LAST)) begin
               state_d = ST_REPEAT;
               rcnt_d  = '0;
               rep_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         rcnt_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         rep_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         press_q   <= rise;
         release_q <= fall;
         rep_q     <= rep_d;
      end
   end

   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_repeat  = rep_q;
   assign o_step    = press_q | rep_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed and random switch patterns against a
// behavioural model (stable-run debounce, arithmetic repeat schedule).
module tb_switch_conditioner;

   localparam int DL = 4;
   localparam int RD = 10;
   localparam int RR = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sw = 1'b0;
   logic level, press, rel, rep, stp;
   logic [4:0] obs;

   int tot = 0;
   int bad = 0;

   switch_conditioner #(
      .DEBOUNCE_LIMIT(DL),
      .REPEAT_EN     (1'b1),
      .REPEAT_DELAY  (RD),
      .REPEAT_RATE   (RR)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_switch (sw),
      .o_level  (level),
      .o_press  (press),
      .o_release(rel),
      .o_repeat (rep),
      .o_step   (stp)
   );

   always #5 clk = ~clk;

   assign obs = {level, press, rel, rep, stp};

   // Model: pin seen two edges late; level flips after DL consecutive
   // disagreeing edges; repeats fall at press_time + RD + k*RR while held.
   logic m_p1, m_p2, m_lvl, m_press, m_rel, m_rep;
   int   run, t, ptime;

   task automatic model_reset();
      m_p1 = 0; m_p2 = 0; m_lvl = 0; m_press = 0; m_rel = 0; m_rep = 0;
      run = 0; t = 0; ptime = 0;
   endtask

   task automatic model_edge();
      t++;
      run = (m_p2 != m_lvl) ? run + 1 : 0;
      m_p2 = m_p1;
      m_p1 = sw;
      m_press = 0;
      m_rel = 0;
      if (run == DL) begin
         m_lvl = ~m_lvl;
         run = 0;
         m_press = m_lvl;
         m_rel = ~m_lvl;
         if (m_lvl) ptime = t;
      end
      m_rep = m_lvl && !m_press && (t - ptime) >= RD && ((t - ptime - RD) % RR) == 0;
   endtask

   function automatic logic [4:0] expv();
      return {m_lvl, m_press, m_rel, m_rep, m_press | m_rep};
   endfunction

   task automatic step(input logic v);
      sw = v;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'($urandom % 2));
         tot++;
         if (obs !== 5'b0) begin
            bad++;
            $display("FAIL reset_hold cyc %0d: got %b want 00000", i, obs);
         end
      end
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0);
         tot++;
         if (obs !== expv()) begin
            bad++;
            $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs, expv());
         end
      end
   endtask

   task automatic test_clean_press();
      int pe, np;
      pe = -1;
      np = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1);
         tot++;
         if (obs !== expv()) begin
            bad++;
            $display("FAIL clean_press cyc %0d: got %b want %b", i, obs, expv());
         end
         if (press) np++;
         if (press && pe < 0) pe = i;
      end
      tot++;
      if (pe !== 5) begin
         bad++;
         $display("FAIL clean_press_edge: got %0d want 5", pe);
      end
      tot++;
      if (np !== 1) begin
         bad++;
         $display("FAIL clean_press_width: got %0d want 1", np);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0);
         tot++;
         if (obs !== expv()) begin
            bad++;
            $display("FAIL clean_release cyc %0d: got %b want %b", i, obs, expv());
         end
      end
   endtask

   task automatic test_bounce();
      logic [13:0] pat;
      pat = 14'b11101110000000;
      for (int i = 13; i >= 0; i--) begin
         step(pat[i]);
         tot++;
         if (obs !== expv() || level || press || stp) begin
            bad++;
            $display("FAIL bounce cyc %0d: got %b want %b", 13 - i, obs, expv());
         end
      end
   endtask

   task automatic test_auto_repeat();
      int pe, nstep;
      int reps[$];
      pe = -1;
      nstep = 0;
      for (int i = 0; i < 26; i++) begin
         step(1'b1);
         tot++;
         if (obs !== expv()) begin
            bad++;
            $display("FAIL auto_repeat cyc %0d: got %b want %b", i, obs, expv());
         end
         if (press && pe < 0) pe = i;
         if (rep) reps.push_back(i - pe);
         if (stp) nstep++;
      end
      tot++;
      if (reps.size() != 4 || reps[0] != 10 || reps[1] != 13 || reps[2] != 16 || reps[3] != 19) begin
         bad++;
         $display("FAIL auto_repeat_times: got %0d pulses want 10,13,16,19", reps.size());
      end
      tot++;
      if (nstep !== 5) begin
         bad++;
         $display("FAIL auto_repeat_steps: got %0d want 5", nstep);
      end
      for (int i = 0; i < 12; i++) begin
         step(1'b0);
         tot++;
         if (obs !== expv()) begin
            bad++;
            $display("FAIL auto_repeat_rel cyc %0d: got %b want %b", i, obs, expv());
         end
      end
   endtask

   task automatic test_release_hold();
      int pe, re, nrep, pe2, fr;
      pe = -1; re = -1; nrep = 0; pe2 = -1; fr = -1;
      for (int i = 0; i < 19; i++) begin
         step(i < 7);
         tot++;
         if (obs !== expv()) begin
            bad++;
            $display("FAIL release_hold cyc %0d: got %b want %b", i, obs, expv());
         end
         if (press && pe < 0) pe = i;
         if (rel && re < 0) re = i;
         if (rep) nrep++;
      end
      tot++;
      if (re - pe !== 7 || nrep !== 0) begin
         bad++;
         $display("FAIL release_hold_timing: got rel@%0d reps %0d want 7 and 0", re - pe, nrep);
      end
      for (int i = 0; i < 28; i++) begin
         step(i < 16);
         tot++;
         if (obs !== expv()) begin
            bad++;
            $display("FAIL repress cyc %0d: got %b want %b", i, obs, expv());
         end
         if (press && pe2 < 0) pe2 = i;
         if (rep && fr < 0) fr = i;
      end
      tot++;
      if (fr - pe2 !== 10) begin
         bad++;
         $display("FAIL repress_delay: got %0d want 10", fr - pe2);
      end
   endtask

   task automatic test_collide();
      int pe, re, late, rep_at_rel;
      pe = -1; re = -1; late = 0; rep_at_rel = 0;
      for (int i = 0; i < 28; i++) begin
         step(i < 13);
         tot++;
         if (obs !== expv()) begin
            bad++;
            $display("FAIL collide cyc %0d: got %b want %b", i, obs, expv());
         end
         if (press && pe < 0) pe = i;
         if (rel && re < 0) begin
            re = i;
            rep_at_rel = rep;
         end
         if (rep && pe >= 0 && i - pe > 10) late++;
      end
      tot++;
      if (re - pe !== 13 || rep_at_rel !== 0 || late !== 0) begin
         bad++;
         $display("FAIL collide_suppress: got rel@%0d rep %0d late %0d want 13 0 0", re - pe, rep_at_rel, late);
      end
   endtask

   task automatic test_async_reset();
      int pe, fr;
      pe = -1; fr = -1;
      for (int i = 0; i < 17; i++) begin
         step(1'b1);
         tot++;
         if (obs !== expv()) begin
            bad++;
            $display("FAIL pre_reset cyc %0d: got %b want %b", i, obs, expv());
         end
      end
      #2 rst_n = 0;
      #1;
      model_reset();
      tot++;
      if (obs !== 5'b0) begin
         bad++;
         $display("FAIL async_reset_now: got %b want 00000", obs);
      end
      step(1'b1);
      step(1'b1);
      tot++;
      if (obs !== 5'b0) begin
         bad++;
         $display("FAIL async_reset_held: got %b want 00000", obs);
      end
      rst_n = 1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1);
         tot++;
         if (obs !== expv()) begin
            bad++;
            $display("FAIL post_reset cyc %0d: got %b want %b", i, obs, expv());
         end
         if (press && pe < 0) pe = i;
         if (rep && fr < 0) fr = i;
      end
      tot++;
      if (pe !== 5 || fr !== 15) begin
         bad++;
         $display("FAIL post_reset_timing: got press %0d rep %0d want 5 15", pe, fr);
      end
      for (int i = 0; i < 10; i++) step(1'b0);
   endtask

   task automatic test_random();
      logic v;
      int len, prev_stp;
      prev_stp = 0;
      for (int r = 0; r < 60; r++) begin
         v = 1'($urandom % 2);
         len = $urandom_range(1, 30);
         for (int j = 0; j < len; j++) begin
            step(v);
            tot++;
            if (obs !== expv() || (stp && prev_stp != 0) || (press && rel)) begin
               bad++;
               $display("FAIL random run %0d cyc %0d: got %b want %b", r, j, obs, expv());
            end
            prev_stp = stp;
         end
      end
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat();
      test_release_hold();
      test_collide();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
